approx_col_mult_seq: RTL and testbench

Sequential controller and datapath for the column-truncated approximate multiplier (PPCT family). It accepts one operand pair plus a runtime truncation threshold `theta` over a valid/ready handshake. It accumulates one truncated partial-product row per cycle, LSB row first, and presents the 2·LEN-bit result on a valid/ready output. It sits between the operand source and the consumer wherever a PPCT multiplier is shared over time instead of unrolled.

---
 rtl/ppct_pkg.sv | 21 ++
 rtl/approx_pp_row.sv | 17 +
 rtl/approx_col_mult_seq.sv | 102 ++++++++++
 tb/tb_approx_col_mult_seq.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/ppct_pkg.sv
// Shared types and helpers for the column-truncated (PPCT) multiplier family.
package ppct_pkg;

  localparam int LEN_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of low bits of x dropped in a given row: theta - row, saturated to [0, len].
  function automatic int theta_clamp(input int theta, input int row, input int len);
    int d;
    d = theta - row;
    if (d < 0) d = 0;
    if (d > len) d = len;
    return d;
  endfunction

endpackage

// File: rtl/approx_pp_row.sv
// One truncated partial-product row: x with its k low bits cleared, gated by y_bit.
module approx_pp_row #(
  parameter int LEN = 8,
  parameter int K_W = $clog2(LEN + 1)
) (
  input  logic [LEN-1:0] x,
  input  logic           y_bit,
  input  logic [K_W-1:0] k,
  output logic [LEN-1:0] pp
);

  logic [LEN-1:0] trunc;

  assign trunc = (x >> k) << k;
  assign pp    = trunc & {LEN{y_bit}};

endmodule

// File: rtl/approx_col_mult_seq.sv
// Sequential PPCT multiplier: one truncated row accumulated per cycle, LSB row first,
// with valid/ready handshakes on both operand and result sides.
module approx_col_mult_seq
  import ppct_pkg::*;
#(
  parameter int LEN     = LEN_DEFAULT,
  parameter int THETA_W = $clog2(2 * LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LEN-1:0]       x,
  input  logic [LEN-1:0]       y,
  input  logic [THETA_W-1:0]   theta,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*LEN-1:0]     z,
  output logic                 busy
);

  localparam int K_W   = $clog2(LEN + 1);
  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic [LEN-1:0]     x_q;
  logic [LEN-1:0]     y_q;
  logic [THETA_W-1:0] theta_q;
  logic [2*LEN-1:0]   acc;

  logic [K_W-1:0]     k;
  logic [LEN-1:0]     pp;
  logic [2*LEN-1:0]   pp_shift;
  logic               last_row;
  logic               accept;

  assign accept   = (state == IDLE) && in_valid;
  assign last_row = (cnt == CNT_W'(LEN - 1));
  assign k        = K_W'(theta_clamp(int'(theta_q), int'(cnt), LEN));
  assign pp_shift = {{LEN{1'b0}}, pp} << cnt;

  approx_pp_row #(
    .LEN (LEN),
    .K_W (K_W)
  ) u_row (
    .x     (x_q),
    .y_bit (y_q[cnt]),
    .k     (k),
    .pp    (pp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = BUSY;
      BUSY:    if (last_row) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gated by rst so the block never advertises readiness while held in reset.
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
    busy      = (state == BUSY) || (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      theta_q <= '0;
      acc     <= '0;
    end else begin
      if (accept) begin
        x_q     <= x;
        y_q     <= y;
        theta_q <= theta;
        acc     <= '0;
        cnt     <= '0;
      end else if (state == BUSY) begin
        acc <= acc + pp_shift;
        cnt <= last_row ? '0 : cnt + CNT_W'(1);
      end
    end
  end

  assign z = acc;

endmodule

// File: tb/tb_approx_col_mult_seq.sv
// Directed and randomized checks of the sequential PPCT multiplier against a row-formula model.
module tb_approx_col_mult_seq;

  localparam int LEN     = 8;
  localparam int THETA_W = 4;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [LEN-1:0]     x;
  logic [LEN-1:0]     y;
  logic [THETA_W-1:0] theta;
  logic               out_valid;
  logic               out_ready;
  logic [2*LEN-1:0]   z;
  logic               busy;

  int n_checks;
  int n_errors;
  int cyc;
  int last_accept;

  approx_col_mult_seq #(
    .LEN     (LEN),
    .THETA_W (THETA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .theta     (theta),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input int xv, input int yv, input int th);
    int acc;
    int k;
    int pp;
    acc = 0;
    for (int i = 0; i < LEN; i++) begin
      k = th - i;
      if (k < 0) k = 0;
      if (k > LEN) k = LEN;
      pp = 0;
      if ((yv >> i) & 1) pp = ((xv >> k) << k) & 255;
      acc = acc + (pp << i);
    end
    return 16'(acc);
  endfunction

  // Waits for in_ready, presents the operands, and returns once the accept edge has passed.
  task automatic issue(input int xv, input int yv, input int th, input string tag);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) chk({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
    x = LEN'(xv); y = LEN'(yv); theta = THETA_W'(th);
    in_valid = 1'b1;
    @(posedge clk);
    if (last_accept >= 0) chk({tag, "_interval_ok"}, 32'((cyc - last_accept + 1) >= LEN + 2), 32'd1);
    last_accept = cyc;
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input int xv, input int yv, input int th, input int m,
                        input logic [15:0] exp, input string tag);
    int edges;
    issue(xv, yv, th, tag);
    edges = 1;
    // Operands change during BUSY; the latched copy must be used.
    x = LEN'($urandom); y = LEN'($urandom); theta = THETA_W'($urandom);
    while (!out_valid && edges < 30) begin
      @(posedge clk); #1;
      edges++;
      x = LEN'($urandom); y = LEN'($urandom); theta = THETA_W'($urandom);
    end
    chk({tag, "_latency"}, 32'(edges - 1), 32'(LEN));
    chk({tag, "_z"}, 32'(z), 32'(exp));
    chk({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
    repeat (m) begin
      @(posedge clk); #1;
    end
    if (m > 0) begin
      chk({tag, "_z_held"}, 32'(z), 32'(exp));
      chk({tag, "_valid_held"}, 32'(out_valid), 32'd1);
      chk({tag, "_in_ready_held"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_valid_after"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_after"}, 32'({in_ready, busy}), 32'b10);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    last_accept = -1;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = '0; y = '0; theta = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_outs", 32'({out_valid, busy}), 32'd0);
    chk("rst_z", 32'(z), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    run_op(255, 255, 0, 0, 16'd65025, "exact");
    run_op(255, 255, 11, 0, 16'd53248, "trunc11");
    run_op(3, 3, 2, 0, 16'd4, "trunc2");
    run_op(200, 77, 15, 0, 16'd0, "full_trunc");
    run_op(200, 77, 0, 5, 16'd15400, "backpressure");

    // Reset while four rows have been accumulated.
    issue(255, 255, 0, "rst_mid");
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_mid_z", 32'(z), 32'd0);
    chk("rst_mid_outs", 32'({in_ready, out_valid, busy}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_accept = -1;
    #1;
    run_op(13, 11, 0, 0, 16'd143, "after_rst");

    for (int i = 0; i < 1000; i++) begin
      int xv, yv, th, m;
      xv = int'($urandom_range(0, 255));
      yv = int'($urandom_range(0, 255));
      th = int'($urandom_range(0, 15));
      m  = int'($urandom_range(0, 3));
      run_op(xv, yv, th, m, model(xv, yv, th), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
